// File: rtl/mul_acc_ctrl.sv
// Multiply-accumulate controller: sums a programmed number of 16-bit products from mul
// into a saturating accumulator, with sticky overflow/saturation flags and a done state.
module mul_acc_ctrl #(
    parameter int unsigned ACC_W = 20,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      prod,
    input  logic             prod_ov,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy,
    output logic             done,
    output logic             ov_flag,
    output logic             sat_flag
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ov_q, ov_d;
    logic             sat_q, sat_d;

    logic             accept;
    logic [ACC_W:0]   sum;

    assign accept = in_valid & (state_q == StRun);
    // One extra bit catches the carry out so saturation can be detected.
    assign sum    = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        len_d   = len_q;
        ov_d    = ov_q;
        sat_d   = sat_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    ov_d    = 1'b0;
                    sat_d   = 1'b0;
                    len_d   = len;
                    state_d = (len != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (accept) begin
                    if (sum[ACC_W]) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                    ov_d    = ov_q | prod_ov;
                    count_d = count_q + LEN_W'(1);
                    if (count_q == len_q - LEN_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            ov_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            ov_q    <= ov_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready = (state_q == StRun);
    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);
    assign acc_out  = acc_q;
    assign ov_flag  = ov_q;
    assign sat_flag = sat_q;

endmodule

// File: tb/tb_mul_acc_ctrl.sv
// Directed self-checking bench for mul_acc_ctrl with hand-computed expected values.
module tb_mul_acc_ctrl;

    localparam int unsigned ACC_W = 20;
    localparam int unsigned LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic [15:0]      prod;
    logic             prod_ov;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             busy;
    logic             done;
    logic             ov_flag;
    logic             sat_flag;

    int errors = 0;
    int checks = 0;

    mul_acc_ctrl #(
        .ACC_W(ACC_W),
        .LEN_W(LEN_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .in_valid(in_valid),
        .prod    (prod),
        .prod_ov (prod_ov),
        .in_ready(in_ready),
        .acc_out (acc_out),
        .busy    (busy),
        .done    (done),
        .ov_flag (ov_flag),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // acc_out, busy, done, in_ready, ov_flag, sat_flag
    task automatic check_all(input string tag, input int acc, input bit b, input bit d,
                             input bit rdy, input bit ov, input bit sat);
        check({tag, ".acc"}, 32'(acc_out), 32'(acc));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".ready"}, 32'(in_ready), 32'(rdy));
        check({tag, ".ov"}, 32'(ov_flag), 32'(ov));
        check({tag, ".sat"}, 32'(sat_flag), 32'(sat));
    endtask

    task automatic feed(input logic [15:0] p, input logic pov);
        in_valid = 1'b1;
        prod     = p;
        prod_ov  = pov;
        step();
        in_valid = 1'b0;
    endtask

    task automatic begin_seq(input logic [LEN_W-1:0] n);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; prod = '0; prod_ov = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        check_all("reset", 0, 0, 0, 0, 0, 0);

        // Basic sequence: 100 + 200 + 300
        begin_seq(8'd3);
        check_all("basic_start", 0, 1, 0, 1, 0, 0);
        feed(16'd100, 1'b0);
        check("basic_acc1", 32'(acc_out), 32'd100);
        feed(16'd200, 1'b0);
        check("basic_acc2", 32'(acc_out), 32'd300);
        check("basic_busy2", 32'(busy), 32'd1);
        feed(16'd300, 1'b0);
        check_all("basic_done", 600, 0, 1, 0, 0, 0);
        in_valid = 1'b1; prod = 16'd50;
        step();
        in_valid = 1'b0;
        check_all("basic_hold", 600, 0, 1, 0, 0, 0);

        // Stalls, overflow flag, start ignored in RUN
        begin_seq(8'd2);
        check_all("stall_start", 0, 1, 0, 1, 0, 0);
        feed(16'd5, 1'b1);
        check_all("stall_acc1", 5, 1, 0, 1, 1, 0);
        start = 1'b1; len = 8'd5;
        step();
        step();
        start = 1'b0;
        check_all("stall_wait", 5, 1, 0, 1, 1, 0);
        feed(16'd7, 1'b0);
        check_all("stall_done", 12, 0, 1, 0, 1, 0);

        // Saturation: 17 x 65535 with ACC_W=20
        begin_seq(8'd17);
        check_all("sat_start", 0, 1, 0, 1, 0, 0);
        in_valid = 1'b1; prod = 16'hFFFF; prod_ov = 1'b0;
        for (int i = 0; i < 16; i++) step();
        check_all("sat_16", 1048560, 1, 0, 1, 0, 0);
        step();
        in_valid = 1'b0;
        check_all("sat_17", 1048575, 0, 1, 0, 0, 1);

        // len == 0 goes straight to DONE and clears flags
        begin_seq(8'd0);
        check_all("len0", 0, 0, 1, 0, 0, 0);
        step();
        check_all("len0_hold", 0, 0, 1, 0, 0, 0);

        // Reset mid-sequence, then restart
        begin_seq(8'd4);
        feed(16'd11, 1'b1);
        feed(16'd22, 1'b0);
        check_all("mid_acc", 33, 1, 0, 1, 1, 0);
        rst = 1'b1; in_valid = 1'b1; prod = 16'd1000; start = 1'b1; len = 8'd3;
        step();
        rst = 1'b0; in_valid = 1'b0; start = 1'b0;
        check_all("mid_reset", 0, 0, 0, 0, 0, 0);
        begin_seq(8'd1);
        feed(16'd9, 1'b1);
        check_all("restart_done", 9, 0, 1, 0, 1, 0);
        begin_seq(8'd2);
        check_all("restart_clear", 0, 1, 0, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
